// File: rtl/config_cmd_parser.sv
// Parses "CONFIG <KEY> [arg1] [arg2]" text lines from a UART byte stream into one
// registered config_valid or parse_error strobe per non-empty line.
module config_cmd_parser #(
  parameter int unsigned MAX_LINE_LEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              config_valid_o,
  output logic [2:0]        config_type_o,
  output logic signed [7:0] config_value1_o,
  output logic signed [7:0] config_value2_o,
  output logic              parse_error_o,
  output logic              line_active_o
);

  localparam int unsigned LenW = $clog2(MAX_LINE_LEN + 1);

  typedef enum logic [2:0] {StIdle, StPrefix, StSep, StKey, StNum, StDiscard} state_e;

  state_e          state_q;
  logic [2:0]      pfx_idx_q;
  logic            sep_seen_q, sep_arg_q;
  logic [47:0]     key_q;
  logic [2:0]      key_type_q;
  logic [1:0]      req_q, argc_q;
  logic [7:0]      arg1_q, arg2_q;
  logic            neg_q;
  logic [1:0]      ndig_q;
  logic [9:0]      mag_q;
  logic [LenW-1:0] len_q;

  logic            config_valid_q, parse_error_q, line_active_q;
  logic [2:0]      cfg_type_q;
  logic [7:0]      value1_q, value2_q;

  logic [7:0] ch, pfx_char, num_val, emit_v1, emit_v2;
  logic [3:0] digit;
  logic [9:0] mag_next;
  logic [2:0] key_type, emit_type;
  logic [1:0] key_req;
  logic       is_letter, is_digit, is_space, is_term, is_minus;
  logic       key_hit, mag_ok, num_ok, term_ok, len_full;

  always_comb begin
    ch = rx_data_i;
    if (ch >= 8'h61 && ch <= 8'h7a) ch = ch - 8'h20;
    is_letter = (ch >= 8'h41) && (ch <= 8'h5a);
    is_digit  = (ch >= 8'h30) && (ch <= 8'h39);
    is_space  = (ch == 8'h20);
    is_term   = (ch == 8'h0d) || (ch == 8'h0a);
    is_minus  = (ch == 8'h2d);
    digit     = ch[3:0];

    case (pfx_idx_q)
      3'd0:    pfx_char = "O";
      3'd1:    pfx_char = "N";
      3'd2:    pfx_char = "F";
      3'd3:    pfx_char = "I";
      default: pfx_char = "G";
    endcase

    // Key buffer is right-aligned and zero-padded, so the length is implied.
    key_hit  = 1'b1;
    key_type = 3'd0;
    key_req  = 2'd0;
    case (key_q)
      {24'd0, "MAX"}:   begin key_type = 3'd0; key_req = 2'd1; end
      {8'd0, "RANGE"}:  begin key_type = 3'd1; key_req = 2'd2; end
      {8'd0, "COUNT"}:  begin key_type = 3'd2; key_req = 2'd1; end
      {16'd0, "SHOW"}:  begin key_type = 3'd3; key_req = 2'd0; end
      "SCALAR":         begin key_type = 3'd4; key_req = 2'd1; end
      default:          key_hit = 1'b0;
    endcase

    mag_next = mag_q * 10'd10 + {6'd0, digit};
    mag_ok   = neg_q ? (mag_q <= 10'd128) : (mag_q <= 10'd127);
    num_val  = neg_q ? (~mag_q[7:0] + 8'd1) : mag_q[7:0];
    num_ok   = (ndig_q != 2'd0) && mag_ok && (argc_q < req_q);
    len_full = (len_q == LenW'(MAX_LINE_LEN));

    case (state_q)
      StSep:   term_ok = sep_arg_q && (argc_q == req_q);
      StKey:   term_ok = key_hit && (key_req == 2'd0);
      StNum:   term_ok = num_ok && ((argc_q + 2'd1) == req_q);
      default: term_ok = 1'b0;
    endcase

    emit_type = (state_q == StKey) ? key_type : key_type_q;
    emit_v1   = (state_q == StNum && argc_q == 2'd0) ? num_val : arg1_q;
    emit_v2   = (state_q == StNum && argc_q == 2'd1) ? num_val : arg2_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      pfx_idx_q      <= 3'd0;
      sep_seen_q     <= 1'b0;
      sep_arg_q      <= 1'b0;
      key_q          <= 48'd0;
      key_type_q     <= 3'd0;
      req_q          <= 2'd0;
      argc_q         <= 2'd0;
      arg1_q         <= 8'd0;
      arg2_q         <= 8'd0;
      neg_q          <= 1'b0;
      ndig_q         <= 2'd0;
      mag_q          <= 10'd0;
      len_q          <= '0;
      config_valid_q <= 1'b0;
      parse_error_q  <= 1'b0;
      line_active_q  <= 1'b0;
      cfg_type_q     <= 3'd0;
      value1_q       <= 8'd0;
      value2_q       <= 8'd0;
    end else begin
      config_valid_q <= 1'b0;
      parse_error_q  <= 1'b0;
      if (rx_valid_i) begin
        if (is_term) begin
          // Empty lines in IDLE are dropped; every other state ends the line here.
          if (state_q != StIdle) begin
            config_valid_q <= term_ok;
            parse_error_q  <= !term_ok;
            line_active_q  <= 1'b0;
            state_q        <= StIdle;
            if (term_ok) begin
              cfg_type_q <= emit_type;
              value1_q   <= emit_v1;
              value2_q   <= emit_v2;
            end
          end
        end else if (state_q inside {StPrefix, StSep, StKey, StNum} && len_full) begin
          state_q <= StDiscard;
        end else begin
          if (state_q != StIdle && state_q != StDiscard) len_q <= len_q + LenW'(1);
          unique case (state_q)
            StIdle: begin
              if (!is_space) begin
                line_active_q <= 1'b1;
                len_q         <= LenW'(1);
                argc_q        <= 2'd0;
                arg1_q        <= 8'd0;
                arg2_q        <= 8'd0;
                pfx_idx_q     <= 3'd0;
                state_q       <= (ch == 8'h43) ? StPrefix : StDiscard;
              end
            end
            StPrefix: begin
              if (ch != pfx_char) begin
                state_q <= StDiscard;
              end else if (pfx_idx_q == 3'd4) begin
                state_q    <= StSep;
                sep_seen_q <= 1'b0;
                sep_arg_q  <= 1'b0;
              end else begin
                pfx_idx_q <= pfx_idx_q + 3'd1;
              end
            end
            StSep: begin
              if (is_space) begin
                sep_seen_q <= 1'b1;
              end else if (!sep_seen_q) begin
                state_q <= StDiscard;
              end else if (!sep_arg_q) begin
                if (is_letter) begin
                  key_q   <= {40'd0, ch};
                  state_q <= StKey;
                end else begin
                  state_q <= StDiscard;
                end
              end else if (is_digit) begin
                neg_q   <= 1'b0;
                mag_q   <= {6'd0, digit};
                ndig_q  <= 2'd1;
                state_q <= StNum;
              end else if (is_minus) begin
                neg_q   <= 1'b1;
                mag_q   <= 10'd0;
                ndig_q  <= 2'd0;
                state_q <= StNum;
              end else begin
                state_q <= StDiscard;
              end
            end
            StKey: begin
              if (is_letter) begin
                if (key_q[47:40] != 8'd0) state_q <= StDiscard;
                else key_q <= {key_q[39:0], ch};
              end else if (is_space && key_hit) begin
                key_type_q <= key_type;
                req_q      <= key_req;
                sep_seen_q <= 1'b1;
                sep_arg_q  <= 1'b1;
                state_q    <= StSep;
              end else begin
                state_q <= StDiscard;
              end
            end
            StNum: begin
              if (is_digit) begin
                if (ndig_q == 2'd3) begin
                  state_q <= StDiscard;
                end else begin
                  mag_q  <= mag_next;
                  ndig_q <= ndig_q + 2'd1;
                end
              end else if (is_space && num_ok) begin
                if (argc_q == 2'd0) arg1_q <= num_val;
                else arg2_q <= num_val;
                argc_q     <= argc_q + 2'd1;
                sep_seen_q <= 1'b1;
                state_q    <= StSep;
              end else begin
                state_q <= StDiscard;
              end
            end
            StDiscard: ;
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  assign config_valid_o  = config_valid_q;
  assign parse_error_o   = parse_error_q;
  assign line_active_o   = line_active_q;
  assign config_type_o   = cfg_type_q;
  assign config_value1_o = value1_q;
  assign config_value2_o = value2_q;

endmodule

// File: tb/tb_config_cmd_parser.sv
// Bench for config_cmd_parser: a token-level line model checked every cycle, plus
// hand-computed expectations per command line.
module tb_config_cmd_parser;

  localparam int unsigned MaxLen = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       config_valid, parse_error, line_active;
  logic [2:0] config_type;
  logic [7:0] config_value1, config_value2;

  always #5 clk = ~clk;

  config_cmd_parser #(.MAX_LINE_LEN(MaxLen)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .config_valid_o (config_valid),
    .config_type_o  (config_type),
    .config_value1_o(config_value1),
    .config_value2_o(config_value2),
    .parse_error_o  (parse_error),
    .line_active_o  (line_active)
  );

  int vectors = 0;
  int miscompares = 0;
  int n_valid = 0;
  int n_err = 0;

  // Model state: expected outputs after the most recent clock edge.
  logic [7:0] line_q[$];
  logic       ev = 1'b0, ee = 1'b0, ea = 1'b0;
  logic [2:0] et = 3'd0;
  logic [7:0] e1 = 8'd0, e2 = 8'd0;
  bit         live = 1'b0;

  // Judges a whole line (leading spaces already stripped) by splitting it into tokens.
  function automatic void eval_line(input logic [7:0] ln[$], output bit ok,
                                    output logic [2:0] ty, output logic [7:0] a1,
                                    output logic [7:0] a2);
    string toks[$];
    string cur;
    int    req;
    logic [7:0] c;
    ok = 1'b0; ty = 3'd0; a1 = 8'd0; a2 = 8'd0; cur = ""; req = 0;
    if (ln.size() > MaxLen) return;
    foreach (ln[i]) begin
      c = ln[i];
      if (c >= "a" && c <= "z") c = c - 8'h20;
      if (c == " ") begin
        if (cur.len() > 0) begin
          toks.push_back(cur);
          cur = "";
        end
      end else if ((c >= "A" && c <= "Z") || (c >= "0" && c <= "9") || c == "-") begin
        cur = $sformatf("%s%c", cur, c);
      end else begin
        return;
      end
    end
    if (cur.len() > 0) toks.push_back(cur);
    if (toks.size() < 2 || toks[0] != "CONFIG") return;
    if (toks[1] == "MAX") begin ty = 3'd0; req = 1; end
    else if (toks[1] == "RANGE") begin ty = 3'd1; req = 2; end
    else if (toks[1] == "COUNT") begin ty = 3'd2; req = 1; end
    else if (toks[1] == "SHOW") begin ty = 3'd3; req = 0; end
    else if (toks[1] == "SCALAR") begin ty = 3'd4; req = 1; end
    else return;
    if (toks.size() != req + 2) return;
    for (int i = 0; i < req; i++) begin
      string s;
      int    st, mag;
      bit    neg;
      s   = toks[i+2];
      neg = (s[0] == "-");
      st  = neg ? 1 : 0;
      if (s.len() - st < 1 || s.len() - st > 3) return;
      mag = 0;
      for (int k = st; k < s.len(); k++) begin
        if (s[k] < "0" || s[k] > "9") return;
        mag = mag * 10 + (int'(s[k]) - 48);
      end
      if (neg ? (mag > 128) : (mag > 127)) return;
      if (i == 0) a1 = neg ? 8'(-mag) : 8'(mag);
      else a2 = neg ? 8'(-mag) : 8'(mag);
    end
    ok = 1'b1;
  endfunction

  always @(posedge clk) begin
    bit         ok;
    logic [2:0] ty;
    logic [7:0] a1, a2;
    ev = 1'b0;
    ee = 1'b0;
    if (!rst_n) begin
      et = 3'd0; e1 = 8'd0; e2 = 8'd0; ea = 1'b0;
      line_q.delete();
      live = 1'b1;
    end else if (rx_valid) begin
      if (rx_data == 8'h0d || rx_data == 8'h0a) begin
        if (line_q.size() > 0) begin
          eval_line(line_q, ok, ty, a1, a2);
          if (ok) begin
            ev = 1'b1; et = ty; e1 = a1; e2 = a2;
          end else begin
            ee = 1'b1;
          end
          line_q.delete();
          ea = 1'b0;
        end
      end else if (!(rx_data == 8'h20 && line_q.size() == 0)) begin
        line_q.push_back(rx_data);
        ea = 1'b1;
      end
    end
  end

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (live) begin
        vectors++;
        if (config_valid !== ev || parse_error !== ee || config_type !== et ||
            config_value1 !== e1 || config_value2 !== e2 || line_active !== ea) begin
          miscompares++;
          $display("FAIL cycle@%0t: got v=%b e=%b ty=%0d v1=%h v2=%h act=%b, want v=%b e=%b ty=%0d v1=%h v2=%h act=%b",
                   $time, config_valid, parse_error, config_type, config_value1, config_value2,
                   line_active, ev, ee, et, e1, e2, ea);
        end
        if (config_valid) n_valid++;
        if (parse_error) n_err++;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line_chk(input string name, input string s, input int dv, input int de,
                          input int ty, input int v1, input int v2);
    int bv, be;
    bv = n_valid;
    be = n_err;
    send_str(s);
    idle(2);
    chk({name, " valid strobes"}, n_valid - bv, dv);
    chk({name, " error strobes"}, n_err - be, de);
    chk({name, " type"}, int'(config_type), ty);
    chk({name, " value1"}, int'(config_value1), v1);
    chk({name, " value2"}, int'(config_value2), v2);
    chk({name, " line_active"}, int'(line_active), 0);
  endtask

  initial begin
    string s;
    int    be;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    fork
      compare_loop();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset valid", int'(config_valid), 0);
    chk("reset error", int'(parse_error), 0);
    chk("reset type", int'(config_type), 0);
    chk("reset value1", int'(config_value1), 0);
    chk("reset active", int'(line_active), 0);

    line_chk("max5 crlf", "CONFIG MAX 5\015\012", 1, 0, 0, 5, 0);
    line_chk("range lower", "config range -3 20\012", 1, 0, 1, 'hFD, 'h14);
    line_chk("scalar -128", "CONFIG SCALAR -128\015", 1, 0, 4, 'h80, 0);
    line_chk("scalar 128", "CONFIG SCALAR 128\015", 0, 1, 4, 'h80, 0);
    line_chk("show arg", "CONFIG SHOW 3\015", 0, 1, 4, 'h80, 0);
    line_chk("show spaced", "  CONFIG   SHOW\015", 1, 0, 3, 0, 0);
    line_chk("three bad",
             "CONFIG FOO 1\015CONFIG MAX 1234\015CONFIG RANGE 5\015", 0, 3, 3, 0, 0);
    line_chk("max127 empties", "CONFIG MAX 127\015\015\012   \012", 1, 0, 0, 127, 0);
    line_chk("count -0", "cOnFiG count -0 \015", 1, 0, 2, 0, 0);
    line_chk("max -129", "CONFIG MAX -129\015", 0, 1, 2, 0, 0);
    line_chk("four bad",
             "CONFIG MAX 5!\015CONFIG\015CONFIGMAX 1\015CONFIG RANGE 1 2 3\015",
             0, 4, 2, 0, 0);
    line_chk("range extremes", "CONFIG RANGE -128 127\015", 1, 0, 1, 'h80, 'h7F);

    s = "CONFIG SHOW";
    while (s.len() < MaxLen) s = {s, " "};
    line_chk("len 32", {s, "\015"}, 1, 0, 3, 0, 0);
    line_chk("len 33", {s, " \015"}, 0, 1, 3, 0, 0);

    // Reset lands mid-line; nothing from the partial line may appear.
    be = n_err;
    send_str("CONFIG MAX 5");
    @(negedge clk);
    rx_valid = 1'b0;
    chk("midline active", int'(line_active), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset type", int'(config_type), 0);
    chk("midreset active", int'(line_active), 0);
    line_chk("count 15", "CONFIG COUNT 15\015", 1, 0, 2, 15, 0);
    chk("midreset no error", n_err - be, 0);

    be = n_err;
    for (int i = 0; i < 20; i++) send_byte("Q");
    #1;
    chk("long active", int'(line_active), 1);
    s = "";
    for (int i = 0; i < 20; i++) s = {s, "Q"};
    line_chk("long 40", {s, "\015"}, 0, 1, 2, 15, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
